bool_sweep_ctrl: RTL
====================

// Module: bool_sweep_ctrl
// PURPOSE
//   Sequencer for the 3-input boolean-expression blocks (A,B,C -> F). On start it walks
//   all 2^N_IN input vectors, holds each for a settle window and samples F. It then
//   assembles the truth table and compares it against an expected table.
//   Sits between a boolean-expression instance and the top-level check logic.
// PARAMETERS
//   N_IN          3   number of expression inputs; vec_out[N_IN-1] = A (MSB)
//   SETTLE_CYCLES 2   extra hold cycles per vector before sampling F; 0 is legal
// PORTS
//   clk        in   1          rising-edge clock
//   rst_n      in   1          asynchronous, active-low reset
//   start      in   1          begin a sweep; accepted only in IDLE or DONE
//   abort      in   1          cancel the sweep in progress; no done pulse
//   exp_tt     in   2^N_IN     expected truth table; bit k = F for vector k
//   f_in       in   1          F output of the expression under control
//   vec_out    out  N_IN       input vector driven to the expression ({A,B,C})
//   busy       out  1          high while a sweep is in progress
//   done       out  1          one-cycle pulse when a sweep completes
//   pass       out  1          tt_out == exp_tt; valid from the done pulse until the next start
//   tt_out     out  2^N_IN     captured truth table; bit k = sampled F for vector k
//   fail_idx   out  N_IN       lowest k with tt_out[k] != exp_tt[k]; 0 when pass
// BEHAVIOUR
//   Reset (async, rst_n=0): state=IDLE; vec_out, busy, done, pass, tt_out, fail_idx
//     and internal counters all go to 0 immediately. Reset mid-sweep discards the sweep.
//   States: IDLE -> HOLD -> (HOLD...) -> DONE -> IDLE.
//   IDLE: start=1 at edge E0 -> HOLD. At E0: vec_out=0, busy=1, tt_out=0, pass=0,
//     fail_idx=0, and the settle counter cnt=0.
//   HOLD: each vector k is held for exactly SETTLE_CYCLES+1 clocks.
//     cnt increments every edge while cnt < SETTLE_CYCLES.
//     At the edge where cnt == SETTLE_CYCLES: tt_out[k] <= f_in and cnt <= 0.
//       If k < 2^N_IN-1: vec_out <= k+1.
//       Otherwise: go to DONE; pass <= (final table == exp_tt); fail_idx <= first mismatch.
//   DONE: lasts one cycle. done=1 and busy=0. vec_out holds the last vector.
//     Next edge: start=1 -> new sweep (as from IDLE); otherwise -> IDLE.
//   Latency: done is high for the cycle starting at edge E0 + 2^N_IN*(SETTLE_CYCLES+1).
//     Defaults give 24 cycles after E0.
//   start while busy: ignored, with no effect on the sweep.
//   abort=1 in HOLD: next edge -> IDLE. busy=0, vec_out=0, no done pulse,
//     pass=0, tt_out keeps its partial contents.
//   abort and start together in IDLE/DONE: start wins. abort is a no-op outside HOLD.
//   exp_tt is sampled only at the final-sample edge; it may change freely otherwise.
//   Mismatch compare: xor of tt and exp_tt; priority-encode the lowest set bit.
//   Widths: the vector index is N_IN bits and never wraps mid-sweep, because the end
//     is detected at index 2^N_IN-1. cnt width is clog2(SETTLE_CYCLES+1), minimum 1.
//   All outputs are registered. No combinational path from inputs to outputs.
// STRUCTURE
//   Shared header bool_sweep_defs.vh holds:
//     state encodings IDLE=2'd0, HOLD=2'd1, DONE=2'd2;
//     localparam N_VEC = 1<<N_IN; the clog2 function.
//   Sub-module settle_timer: counts 0..SETTLE_CYCLES and asserts a one-cycle tick
//     on the last count. Inputs clr and en; async active-low reset.
//   The FSM, vector index, capture register and compare logic stay in bool_sweep_ctrl.
// TESTING
//   Bench models F=(A&B)|C on vec_out, giving truth table 8'hEA. Defaults throughout.
//   1 Reset at time 0, then release -> all outputs 0, state IDLE, vec_out=3'b000.
//   2 start pulse, exp_tt=8'hEA -> vec_out steps 0..7, 3 clocks each; done at E0+24;
//     tt_out=8'hEA, pass=1, fail_idx=0.
//   3 exp_tt=8'hEB -> done at E0+24, pass=0, fail_idx=0.
//     exp_tt=8'h6A -> pass=0, fail_idx=7.
//   4 start re-pulsed at E0+5 (busy) -> ignored, done still at E0+24;
//     start held high in the DONE cycle -> second sweep begins, done again 24 cycles later.
//   5 rst_n low at E0+10 -> outputs 0 asynchronously; after release, a start gives a
//     clean sweep, pass=1.
//   6 abort at vector 4 -> busy=0 next edge, no done pulse, tt_out[7:4]=0.
//     Separately, SETTLE_CYCLES=0 -> done at E0+8, tt_out=8'hEA.

Source files
------------

// File: rtl/bool_sweep_ctrl_pkg.sv
// Shared types and helpers for the boolean-expression sweep controller.
// State encoding is fixed so the encoding seen on a debug probe stays stable.
package bool_sweep_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    DONE = 2'd2
  } state_e;

  // ceil(log2(v)), never below 1 so a zero-settle counter still has a bit
  function automatic int clog2_min1(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/bool_sweep_ctrl_if.sv
// Bus between the sweep controller (slave) and the check logic / expression (master).
// N_IN must match the controller's N_IN parameter.
interface bool_sweep_ctrl_if #(parameter int N_IN = 3);

  localparam int N_VEC = 1 << N_IN;

  logic             start;
  logic             abort;
  logic [N_VEC-1:0] exp_tt;
  logic             f_in;
  logic [N_IN-1:0]  vec_out;
  logic             busy;
  logic             done;
  logic             pass;
  logic [N_VEC-1:0] tt_out;
  logic [N_IN-1:0]  fail_idx;

  modport master (
    output start, abort, exp_tt, f_in,
    input  vec_out, busy, done, pass, tt_out, fail_idx
  );

  modport slave (
    input  start, abort, exp_tt, f_in,
    output vec_out, busy, done, pass, tt_out, fail_idx
  );

endinterface

// File: rtl/bool_sweep_ctrl_settle_timer.sv
// Settle counter: counts 0..SETTLE_CYCLES while en, tick is high on the last count.
// clr has priority over en and returns the count to 0.
module settle_timer
  import bool_sweep_ctrl_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic tick_o
);

  localparam int CW = clog2_min1(SETTLE_CYCLES + 1);

  logic [CW-1:0] cnt_q;
  logic          last;

  assign last   = (cnt_q == CW'(SETTLE_CYCLES));
  assign tick_o = en_i && last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= last ? '0 : cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/bool_sweep_ctrl.sv
// Walks all 2^N_IN input vectors, holds each SETTLE_CYCLES+1 clocks, samples F into a
// truth table and compares it with exp_tt. All bus outputs are registered.
module bool_sweep_ctrl
  import bool_sweep_ctrl_pkg::*;
#(
  parameter int N_IN          = 3,
  parameter int SETTLE_CYCLES = 2
) (
  input logic             clk,
  input logic             rst_n,
  bool_sweep_ctrl_if.slave bus
);

  localparam int N_VEC = 1 << N_IN;

  state_e           state_q;
  logic [N_IN-1:0]  vec_q;
  logic             busy_q;
  logic             done_q;
  logic             pass_q;
  logic [N_VEC-1:0] tt_q;
  logic [N_IN-1:0]  fail_q;

  logic             tick;
  logic [N_VEC-1:0] tt_d;
  logic [N_VEC-1:0] diff;
  logic [N_IN-1:0]  fail_d;

  // Timer is held at 0 outside HOLD, so every sweep starts with a full settle window
  settle_timer #(.SETTLE_CYCLES(SETTLE_CYCLES)) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  ((state_q != HOLD) || bus.abort),
    .en_i   (state_q == HOLD),
    .tick_o (tick)
  );

  // Table as it will look after this edge's sample; lowest mismatching bit wins
  always_comb begin
    tt_d        = tt_q;
    tt_d[vec_q] = bus.f_in;
    diff        = tt_d ^ bus.exp_tt;
    fail_d      = '0;
    for (int k = N_VEC - 1; k >= 0; k--) begin
      if (diff[k]) fail_d = N_IN'(k);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      vec_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      tt_q    <= '0;
      fail_q  <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (bus.start) begin
            state_q <= HOLD;
            vec_q   <= '0;
            busy_q  <= 1'b1;
            tt_q    <= '0;
            pass_q  <= 1'b0;
            fail_q  <= '0;
          end else begin
            state_q <= IDLE;
          end
        end
        HOLD: begin
          if (bus.abort) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            vec_q   <= '0;
            pass_q  <= 1'b0;
          end else if (tick) begin
            tt_q <= tt_d;
            if (vec_q == N_IN'(N_VEC - 1)) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              pass_q  <= (diff == '0);
              fail_q  <= fail_d;
            end else begin
              vec_q <= vec_q + N_IN'(1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.vec_out  = vec_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.pass     = pass_q;
  assign bus.tt_out   = tt_q;
  assign bus.fail_idx = fail_q;

endmodule
